// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset main controller.
// Ports: none (package) -- opcode/funct codes, state codes, datapath select codes,
//        instruction-class struct and small class helper functions.
package mc_ctrl_pkg;

    // Controller states; codes 5-7 are unused and recover to FETCH.
    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_DCD   = 3'd1,
        S_EXE   = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4
    } state_e;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    // Next-PC source
    localparam logic [1:0] NPC_SEQ  = 2'b00;  // pc + 4
    localparam logic [1:0] NPC_BR   = 2'b01;  // pc + 4 + (imm << 2)
    localparam logic [1:0] NPC_JMP  = 2'b10;  // {pc[31:28], imm26, 2'b00}
    localparam logic [1:0] NPC_RS   = 2'b11;  // register rs

    // Destination register select
    localparam logic [1:0] WR_RT    = 2'b00;
    localparam logic [1:0] WR_RD    = 2'b01;
    localparam logic [1:0] WR_RA    = 2'b10;  // $31

    // Register write-data select
    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_DM    = 2'b01;
    localparam logic [1:0] WD_PC    = 2'b10;  // pc register, already advanced by 4

    // Immediate extension
    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    // ALU operation
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;

    // One-hot instruction class produced by mc_decode.
    typedef struct packed {
        logic rtype_alu;   // addu / subu
        logic jr;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic illegal;     // anything unsupported, executed as a nop
    } insn_class_t;

    // Instructions that retire in DCD (2-cycle CPI).
    function automatic logic ends_in_dcd(insn_class_t c);
        return c.j | c.jal | c.jr | c.illegal;
    endfunction

    // Instructions that write the register file in WB.
    function automatic logic writes_rf_in_wb(insn_class_t c);
        return c.rtype_alu | c.ori | c.lui | c.lw;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct decoder producing a one-hot instruction class.
// Ports: op_i   [5:0] IR[31:26]      funct_i [5:0] IR[5:0]
//        cls_o  one-hot class; exactly one bit set for every input code.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0]  op_i,
    input  logic [5:0]  funct_i,
    output insn_class_t cls_o
);

    always_comb begin
        cls_o = '0;
        case (op_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADDU,
                    FN_SUBU: cls_o.rtype_alu = 1'b1;
                    FN_JR:   cls_o.jr        = 1'b1;
                    default: cls_o.illegal   = 1'b1;
                endcase
            end
            OP_ORI:  cls_o.ori     = 1'b1;
            OP_LUI:  cls_o.lui     = 1'b1;
            OP_LW:   cls_o.lw      = 1'b1;
            OP_SW:   cls_o.sw      = 1'b1;
            OP_BEQ:  cls_o.beq     = 1'b1;
            OP_J:    cls_o.j       = 1'b1;
            OP_JAL:  cls_o.jal     = 1'b1;
            default: cls_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller for the MIPS-subset datapath: sequences PC/IR updates,
// register-file, data-memory and ALU controls over FETCH/DCD/EXE/MEM/WB.
// Ports: clk, rst (async active-high); op/funct from IR; zero from ALU (valid in EXE);
//        stall freezes the state and kills all write enables; pc_we/npc_sel drive the pc
//        and npc unit; ir_we/rf_we/dm_we are write enables; wr_sel/wd_sel/ext_op/alu_op/
//        alub_sel are datapath selects; state is the current state for debug.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W = 3
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               stall,
    output logic               pc_we,
    output logic [1:0]         npc_sel,
    output logic               ir_we,
    output logic               rf_we,
    output logic               dm_we,
    output logic [1:0]         wr_sel,
    output logic [1:0]         wd_sel,
    output logic [1:0]         ext_op,
    output logic [1:0]         alu_op,
    output logic               alub_sel,
    output logic [STATE_W-1:0] state
);

    insn_class_t cls;
    state_e      state_q;
    state_e      state_d;

    // Raw enables before stall/reset gating.
    logic        pc_en;
    logic        ir_en;
    logic        rf_en;
    logic        dm_en;

    mc_decode u_decode (
        .op_i    (op),
        .funct_i (funct),
        .cls_o   (cls)
    );

    // ------------------------------------------------------------------
    // State register. stall simply holds the current state so that the
    // same state's enables reappear when the stall is released.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else if (!stall) begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DCD;
            S_DCD: begin
                // Jumps complete in DCD; unsupported codes fall straight back.
                if (ends_in_dcd(cls)) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                if (cls.lw || cls.sw) begin
                    state_d = S_MEM;
                end else if (writes_rf_in_wb(cls)) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FETCH;   // beq resolves here
                end
            end
            S_MEM: begin
                if (cls.lw) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WB:    state_d = S_FETCH;
            default: state_d = S_FETCH;  // unused codes recover
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode. Selects depend only on the instruction class once
    // past FETCH, so they stay stable from DCD through MEM/WB; enables
    // are state-specific and are killed by stall and rst.
    // ------------------------------------------------------------------
    always_comb begin
        pc_en    = 1'b0;
        ir_en    = 1'b0;
        rf_en    = 1'b0;
        dm_en    = 1'b0;
        npc_sel  = NPC_SEQ;
        wr_sel   = WR_RT;
        wd_sel   = WD_ALU;
        ext_op   = EXT_ZERO;
        alu_op   = ALU_ADD;
        alub_sel = 1'b0;

        if (state_q == S_DCD || state_q == S_EXE ||
            state_q == S_MEM || state_q == S_WB) begin
            if (cls.rtype_alu) begin
                wr_sel = WR_RD;
                alu_op = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
            end
            if (cls.ori) begin
                alu_op   = ALU_OR;
                ext_op   = EXT_ZERO;
                alub_sel = 1'b1;
            end
            if (cls.lui) begin
                // rs is $0 for lui, so add passes the shifted immediate through.
                ext_op   = EXT_LUI;
                alub_sel = 1'b1;
            end
            if (cls.lw || cls.sw) begin
                ext_op   = EXT_SIGN;
                alub_sel = 1'b1;
            end
            if (cls.lw) begin
                wd_sel = WD_DM;
            end
            if (cls.beq) begin
                alu_op  = ALU_SUB;
                npc_sel = NPC_BR;
            end
            if (cls.j || cls.jal) begin
                npc_sel = NPC_JMP;
            end
            if (cls.jal) begin
                wr_sel = WR_RA;
                wd_sel = WD_PC;
            end
            if (cls.jr) begin
                npc_sel = NPC_RS;
            end
        end

        case (state_q)
            S_FETCH: begin
                ir_en = 1'b1;
                pc_en = 1'b1;
            end
            S_DCD: begin
                pc_en = cls.j | cls.jal | cls.jr;
                rf_en = cls.jal;
            end
            S_EXE: begin
                pc_en = cls.beq & zero;
            end
            S_MEM: begin
                dm_en = cls.sw;
            end
            S_WB: begin
                rf_en = writes_rf_in_wb(cls);
            end
            default: begin
            end
        endcase

        pc_we = pc_en & ~stall & ~rst;
        ir_we = ir_en & ~stall & ~rst;
        rf_we = rf_en & ~stall & ~rst;
        dm_we = dm_en & ~stall & ~rst;
    end

    assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       pc_we;
        logic [1:0] npc;
        logic       ir;
        logic       rf;
        logic       dm;
        logic [1:0] wr;
        logic [1:0] wd;
        logic [1:0] ext;
        logic [1:0] alu;
        logic       alub;
    } snap_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       stall;
    logic       pc_we;
    logic [1:0] npc_sel;
    logic       ir_we;
    logic       rf_we;
    logic       dm_we;
    logic [1:0] wr_sel;
    logic [1:0] wd_sel;
    logic [1:0] ext_op;
    logic [1:0] alu_op;
    logic       alub_sel;
    logic [2:0] state;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] regs [32];
    logic [31:0] pc;
    logic [31:0] pc_fetch;
    snap_t       trace [$];

    always #5 clk = ~clk;

    mc_ctrl #(.STATE_W(3)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .stall(stall),
        .pc_we(pc_we), .npc_sel(npc_sel), .ir_we(ir_we), .rf_we(rf_we), .dm_we(dm_we),
        .wr_sel(wr_sel), .wd_sel(wd_sel), .ext_op(ext_op), .alu_op(alu_op),
        .alub_sel(alub_sel), .state(state)
    );

    function automatic logic [31:0] sext16(logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    // Data memory contents as a fixed function of address.
    function automatic logic [31:0] dm_rd(logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h1357_9BDF;
    endfunction

    task automatic do_reset;
        rst   = 1'b1;
        stall = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        pc  = 32'h0000_3000;
    endtask

    // Executes one instruction on a behavioural datapath driven by the DUT controls,
    // and compares its architectural effect with the instruction's semantics.
    task automatic run_insn(input logic [31:0] instr, input int stall_pct);
        logic [4:0]  rs, rt, rd, dst, got_dst;
        logic [15:0] imm;
        logic [31:0] seq, a, b, res, nxt, wdat, got_wd, got_da, got_dd;
        logic [31:0] exp_pc, exp_wd, exp_da, exp_dd;
        logic [4:0]  exp_dst;
        int          exp_cpi, exp_rf, exp_dm, n_ir, n_rf, n_dm, active, guard;
        bit          do_wr;
        rs = instr[25:21]; rt = instr[20:16]; rd = instr[15:11]; imm = instr[15:0];
        seq = pc + 32'd4;
        exp_cpi = 2; exp_pc = seq; exp_rf = 0; exp_dm = 0;
        exp_dst = '0; exp_wd = '0; exp_da = '0; exp_dd = '0;
        case (instr[31:26])
            6'h00: case (instr[5:0])
                6'h21: begin exp_cpi = 4; exp_rf = 1; exp_dst = rd; exp_wd = regs[rs] + regs[rt]; end
                6'h23: begin exp_cpi = 4; exp_rf = 1; exp_dst = rd; exp_wd = regs[rs] - regs[rt]; end
                6'h08: exp_pc = regs[rs];
                default: ;
            endcase
            6'h0D: begin exp_cpi = 4; exp_rf = 1; exp_dst = rt; exp_wd = regs[rs] | {16'h0, imm}; end
            6'h0F: begin exp_cpi = 4; exp_rf = 1; exp_dst = rt; exp_wd = {imm, 16'h0}; end
            6'h23: begin exp_cpi = 5; exp_rf = 1; exp_dst = rt; exp_wd = dm_rd(regs[rs] + sext16(imm)); end
            6'h2B: begin exp_cpi = 4; exp_dm = 1; exp_da = regs[rs] + sext16(imm); exp_dd = regs[rt]; end
            6'h04: begin
                exp_cpi = 3;
                if (regs[rs] == regs[rt]) exp_pc = seq + (sext16(imm) << 2);
            end
            6'h02: exp_pc = {seq[31:28], instr[25:0], 2'b00};
            6'h03: begin
                exp_pc = {seq[31:28], instr[25:0], 2'b00};
                exp_rf = 1; exp_dst = 5'd31; exp_wd = seq;
            end
            default: ;
        endcase

        op = instr[31:26]; funct = instr[5:0]; zero = (regs[rs] == regs[rt]);
        trace.delete();
        n_ir = 0; n_rf = 0; n_dm = 0; active = 0; guard = 0;
        got_dst = '0; got_wd = '0; got_da = '0; got_dd = '0;
        n_chk++;
        if (state !== 3'd0) $display("FAIL start_state instr=%08h: got %0d want 0", instr, state);
        else n_pass++;
        while (1) begin
            stall = ($urandom_range(99) < stall_pct);
            @(negedge clk);
            guard++;
            if (!stall) begin
                active++;
                trace.push_back('{state, pc_we, npc_sel, ir_we, rf_we, dm_we,
                                  wr_sel, wd_sel, ext_op, alu_op, alub_sel});
            end
            a = regs[rs];
            case (ext_op)
                2'b00:   b = {16'h0, imm};
                2'b01:   b = sext16(imm);
                2'b10:   b = {imm, 16'h0};
                default: b = '0;
            endcase
            if (!alub_sel) b = regs[rt];
            case (alu_op)
                2'b00:   res = a + b;
                2'b01:   res = a - b;
                2'b10:   res = a | b;
                default: res = '0;
            endcase
            nxt = pc;
            if (ir_we) begin n_ir++; pc_fetch = pc; end
            if (pc_we) begin
                case (npc_sel)
                    2'b00: nxt = pc + 32'd4;
                    2'b01: nxt = pc_fetch + 32'd4 + (sext16(imm) << 2);
                    2'b10: nxt = {pc_fetch[31:28], instr[25:0], 2'b00};
                    default: nxt = regs[rs];
                endcase
            end
            do_wr = 1'b0; dst = '0; wdat = '0;
            if (rf_we) begin
                n_rf++; do_wr = 1'b1;
                case (wr_sel)
                    2'b00: dst = rt;
                    2'b01: dst = rd;
                    2'b10: dst = 5'd31;
                    default: dst = 5'd0;
                endcase
                case (wd_sel)
                    2'b00: wdat = res;
                    2'b01: wdat = dm_rd(res);
                    2'b10: wdat = pc;
                    default: wdat = 32'hDEAD_BEEF;
                endcase
                got_dst = dst; got_wd = wdat;
            end
            if (dm_we) begin n_dm++; got_da = res; got_dd = regs[rt]; end
            pc = nxt;
            if (do_wr && dst != 5'd0) regs[dst] = wdat;
            @(posedge clk); #1;
            if (state == 3'd0 && active > 0) break;
            if (guard >= 40) break;
        end
        stall = 1'b0;
        n_chk++;
        if (guard >= 40) $display("FAIL timeout instr=%08h: no return to FETCH after %0d cycles", instr, guard);
        else n_pass++;
        n_chk++;
        if (active !== exp_cpi) $display("FAIL cpi instr=%08h: got %0d want %0d", instr, active, exp_cpi);
        else n_pass++;
        n_chk++;
        if (pc !== exp_pc) $display("FAIL next_pc instr=%08h: got %08h want %08h", instr, pc, exp_pc);
        else n_pass++;
        n_chk++;
        if (n_ir !== 1) $display("FAIL ir_loads instr=%08h: got %0d want 1", instr, n_ir);
        else n_pass++;
        n_chk++;
        if (n_rf !== exp_rf) $display("FAIL rf_writes instr=%08h: got %0d want %0d", instr, n_rf, exp_rf);
        else n_pass++;
        if (exp_rf == 1 && n_rf == 1) begin
            n_chk++;
            if ({got_dst, got_wd} !== {exp_dst, exp_wd})
                $display("FAIL rf_data instr=%08h: got r%0d=%08h want r%0d=%08h",
                         instr, got_dst, got_wd, exp_dst, exp_wd);
            else n_pass++;
        end
        n_chk++;
        if (n_dm !== exp_dm) $display("FAIL dm_writes instr=%08h: got %0d want %0d", instr, n_dm, exp_dm);
        else n_pass++;
        if (exp_dm == 1 && n_dm == 1) begin
            n_chk++;
            if ({got_da, got_dd} !== {exp_da, exp_dd})
                $display("FAIL dm_data instr=%08h: got [%08h]=%08h want [%08h]=%08h",
                         instr, got_da, got_dd, exp_da, exp_dd);
            else n_pass++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; stall = 1'b0; op = 6'h00; funct = 6'h21; zero = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({state, pc_we, ir_we, rf_we, dm_we, npc_sel, wr_sel, wd_sel, ext_op, alu_op, alub_sel} !== '0)
            $display("FAIL reset_outputs: got st=%0d en=%b%b%b%b want all 0", state, pc_we, ir_we, rf_we, dm_we);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({state, ir_we, pc_we} !== {3'd0, 2'b11})
            $display("FAIL first_fetch: got st=%0d ir_we=%b pc_we=%b want 0 1 1", state, ir_we, pc_we);
        else n_pass++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_chk++;
        if (state !== 3'd2) $display("FAIL reach_exe: got %0d want 2", state);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_chk++;
        if ({state, pc_we, ir_we, rf_we, dm_we} !== '0)
            $display("FAIL rst_mid_exe: got st=%0d en=%b%b%b%b want all 0", state, pc_we, ir_we, rf_we, dm_we);
        else n_pass++;
        @(posedge clk); #1;
        n_chk++;
        if ({state, pc_we, ir_we, rf_we, dm_we} !== '0)
            $display("FAIL rst_held: got st=%0d en=%b%b%b%b want all 0", state, pc_we, ir_we, rf_we, dm_we);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({state, ir_we, pc_we} !== {3'd0, 2'b11})
            $display("FAIL post_rst_fetch: got st=%0d ir_we=%b pc_we=%b want 0 1 1", state, ir_we, pc_we);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_addu;
        regs[1] = 32'h0000_1234; regs[2] = 32'h0000_0101;
        run_insn(32'h0022_1821, 0);
        n_chk++;
        if ({trace[0].st, trace[1].st, trace[2].st, trace[3].st} !== {3'd0, 3'd1, 3'd2, 3'd4})
            $display("FAIL addu_states: got %0d,%0d,%0d,%0d want 0,1,2,4",
                     trace[0].st, trace[1].st, trace[2].st, trace[3].st);
        else n_pass++;
        n_chk++;
        if ({trace[3].rf, trace[3].wr, trace[3].wd} !== {1'b1, 2'b01, 2'b00})
            $display("FAIL addu_wb: got rf=%b wr=%b wd=%b want 1 01 00", trace[3].rf, trace[3].wr, trace[3].wd);
        else n_pass++;
        n_chk++;
        if ({trace[0].pc_we, trace[1].pc_we, trace[2].pc_we, trace[3].pc_we} !== 4'b1000)
            $display("FAIL addu_pc_once: got %b want 1000",
                     {trace[0].pc_we, trace[1].pc_we, trace[2].pc_we, trace[3].pc_we});
        else n_pass++;
        n_chk++;
        if ({trace[0].npc, trace[0].wr, trace[0].wd, trace[0].ext, trace[0].alu, trace[0].alub} !== '0)
            $display("FAIL fetch_selects: got %b want 0",
                     {trace[0].npc, trace[0].wr, trace[0].wd, trace[0].ext, trace[0].alu, trace[0].alub});
        else n_pass++;
    endtask

    task automatic test_beq;
        regs[1] = 32'h55; regs[2] = 32'h55;
        run_insn(32'h1022_0005, 0);
        n_chk++;
        if ({trace[2].pc_we, trace[2].npc} !== {1'b1, 2'b01})
            $display("FAIL beq_taken: got pc_we=%b npc=%b want 1 01", trace[2].pc_we, trace[2].npc);
        else n_pass++;
        regs[2] = 32'h56;
        run_insn(32'h1022_0005, 0);
        n_chk++;
        if (trace[2].pc_we !== 1'b0) $display("FAIL beq_not_taken: got pc_we=%b want 0", trace[2].pc_we);
        else n_pass++;
    endtask

    task automatic test_lw_sw;
        run_insn(32'h8C22_0004, 0);
        n_chk++;
        if ({trace[3].st, trace[3].dm, trace[4].wd, trace[4].ext} !== {3'd3, 1'b0, 2'b01, 2'b01})
            $display("FAIL lw_mem_wb: got st=%0d dm=%b wd=%b ext=%b want 3 0 01 01",
                     trace[3].st, trace[3].dm, trace[4].wd, trace[4].ext);
        else n_pass++;
        run_insn(32'hAC22_0004, 0);
        n_chk++;
        if ({trace[3].st, trace[3].dm} !== {3'd3, 1'b1})
            $display("FAIL sw_mem: got st=%0d dm=%b want 3 1", trace[3].st, trace[3].dm);
        else n_pass++;
    endtask

    task automatic test_jal_jr;
        run_insn(32'h0C00_0C10, 0);
        n_chk++;
        if ({trace[1].pc_we, trace[1].npc, trace[1].rf, trace[1].wr, trace[1].wd} !== {1'b1, 2'b10, 1'b1, 2'b10, 2'b10})
            $display("FAIL jal_dcd: got %b want 1_10_1_10_10",
                     {trace[1].pc_we, trace[1].npc, trace[1].rf, trace[1].wr, trace[1].wd});
        else n_pass++;
        run_insn(32'h03E0_0008, 0);
        n_chk++;
        if ({trace[1].pc_we, trace[1].npc} !== {1'b1, 2'b11})
            $display("FAIL jr_dcd: got pc_we=%b npc=%b want 1 11", trace[1].pc_we, trace[1].npc);
        else n_pass++;
    endtask

    task automatic test_nop;
        run_insn(32'hFC00_0000, 0);
        n_chk++;
        if ({trace[1].pc_we, trace[1].ir, trace[1].rf, trace[1].dm} !== 4'b0000)
            $display("FAIL nop_dcd: got en=%b want 0000",
                     {trace[1].pc_we, trace[1].ir, trace[1].rf, trace[1].dm});
        else n_pass++;
    endtask

    task automatic test_stall;
        int i;
        op = 6'h00; funct = 6'h21; zero = 1'b0; stall = 1'b0;
        for (i = 0; i < 6 && state !== 3'd4; i++) begin
            @(posedge clk); #1;
        end
        n_chk++;
        if (state !== 3'd4) $display("FAIL stall_reach_wb: got %0d want 4", state);
        else n_pass++;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_chk++;
            if ({state, rf_we, wr_sel} !== {3'd4, 1'b0, 2'b01})
                $display("FAIL stall_hold%0d: got st=%0d rf_we=%b wr=%b want 4 0 01", k, state, rf_we, wr_sel);
            else n_pass++;
            @(posedge clk); #1;
        end
        stall = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({state, rf_we} !== {3'd4, 1'b1})
            $display("FAIL stall_release: got st=%0d rf_we=%b want 4 1", state, rf_we);
        else n_pass++;
        @(posedge clk); #1;
        n_chk++;
        if (state !== 3'd0) $display("FAIL stall_done: got %0d want 0", state);
        else n_pass++;
        do_reset();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); imm = 16'($urandom);
        case ($urandom_range(10))
            0:  return {6'h00, rs, rt, rd, 5'h0, 6'h21};
            1:  return {6'h00, rs, rt, rd, 5'h0, 6'h23};
            2:  return {6'h00, rs, 15'h0, 6'h08};
            3:  return {6'h0D, rs, rt, imm};
            4:  return {6'h0F, 5'h0, rt, imm};
            5:  return {6'h23, rs, rt, imm};
            6:  return {6'h2B, rs, rt, imm};
            7:  return {6'h04, rs, ($urandom_range(1) == 1) ? rs : rt, imm};
            8:  return {6'h02, 26'($urandom)};
            9:  return {6'h03, 26'($urandom)};
            default: return ($urandom_range(1) == 1) ? {6'h3F, 26'($urandom)}
                                                     : {6'h00, rs, rt, rd, 5'h0, 6'h2A};
        endcase
    endfunction

    task automatic test_random;
        for (int n = 0; n < 250; n++) begin
            run_insn(rand_instr(), 20);
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; op = '0; funct = '0; zero = 1'b0;
        regs[0] = '0;
        for (int i = 1; i < 32; i++) regs[i] = $urandom;
        pc = 32'h0000_3000; pc_fetch = pc;
        test_reset();
        test_addu();
        test_beq();
        test_lw_sw();
        test_jal_jr();
        test_nop();
        test_stall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
